// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/sequencing stage: FSM state encoding,
// default PC width, and the halt opcode shared with the decoder.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_e;

  localparam int         PC_W_DEFAULT = 10;
  localparam logic [3:0] HALT_OPCODE  = 4'b1111;

endpackage

// File: rtl/fetch_inst_counter.sv
// Saturating 16-bit retired-instruction counter. Only instantiated when
// FETCH_INST_COUNT_EN is defined.
module fetch_inst_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and run/done sequencing downstream of the ALU.
// Optional retired-instruction counter enabled by FETCH_INST_COUNT_EN.
//
// state | meaning
// IDLE  | after reset, PC holds, waiting for Start
// RUN   | fetching; PC advances or branches each non-stalled cycle
// DONE  | halt retired, PC parked on the halt instruction until Start
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Branch,
  input  logic [7:0]      Target,
  input  logic            Halt,
  output logic [PC_W-1:0] PC,
  output logic            Running,
  output logic            Done
`ifdef FETCH_INST_COUNT_EN
  ,
  output logic [15:0]     InstCount
`endif
);

  localparam logic [1:0] ST_IDLE = FETCH_IDLE;
  localparam logic [1:0] ST_RUN  = FETCH_RUN;
  localparam logic [1:0] ST_DONE = FETCH_DONE;

  logic [1:0]      state;
  logic [PC_W-1:0] offset;

  // Target is a signed byte; widen to PC_W so the add wraps modulo 2^PC_W.
  assign offset = PC_W'(signed'(Target));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      PC    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            state <= ST_RUN;
            PC    <= START_ADDR;
          end
        end
        ST_RUN: begin
          if (!Stall) begin
            if (Halt) begin
              state <= ST_DONE;
            end else if (Branch) begin
              PC <= PC + offset;
            end else begin
              PC <= PC + PC_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pure decode of the state flop, so no input reaches these outputs combinationally.
  assign Running = (state == ST_RUN);
  assign Done    = (state == ST_DONE);

`ifdef FETCH_INST_COUNT_EN
  fetch_inst_counter u_inst_counter (
    .clk   (Clk),
    .reset (Reset),
    .clear (Start && (state != ST_RUN)),
    .inc   ((state == ST_RUN) && !Stall),
    .count (InstCount)
  );
`endif

endmodule
